// File: rtl/base_mul_seq.sv
// Kyber pointwise base multiply over NPAIR coefficient pairs.
// Reads A/B/gamma by pair index, writes {c1,c0} three cycles after each read.
module base_mul_seq #(
   parameter int Q     = 3329,
   parameter int NPAIR = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [6:0]  rd_addr,
   input  logic [31:0] a_rdata,
   input  logic [31:0] b_rdata,
   input  logic [15:0] gamma_rdata,
   output logic        c_we,
   output logic [6:0]  c_addr,
   output logic [31:0] c_wdata
);

   localparam int             QW   = $clog2(Q);
   localparam int             RW   = 34;
   localparam logic [6:0]     LAST = 7'(NPAIR - 1);
   localparam logic [RW-1:0]  QL   = RW'(Q);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   // Restoring division remainder: exact for any RW-bit operand.
   function automatic logic [QW-1:0] mod_q(input logic [RW-1:0] x);
      logic [RW-1:0] r;
      r = x;
      for (int i = RW - QW; i >= 0; i--) begin
         if (r >= (QL << i)) begin
            r = r - (QL << i);
         end
      end
      return QW'(r);
   endfunction

   state_t        state_q;
   logic          busy_q;
   logic          done_q;
   logic          rd_en_q;
   logic [6:0]    rd_addr_q;

   logic          rv_q;
   logic [6:0]    rk_q;

   logic          pv_q;
   logic [6:0]    pk_q;
   logic [31:0]   p00_q;
   logic [QW-1:0] m11_q;
   logic [32:0]   px_q;
   logic [15:0]   g_q;

   logic          c_we_q;
   logic [6:0]    c_addr_q;
   logic [31:0]   c_wdata_q;

   logic [15:0]   a0;
   logic [15:0]   a1;
   logic [15:0]   b0;
   logic [15:0]   b1;
   logic [31:0]   p00_d;
   logic [31:0]   p11_d;
   logic [32:0]   px_d;
   logic [QW-1:0] m11_d;
   logic [RW-1:0] s0_d;
   logic [QW-1:0] c0_d;
   logic [QW-1:0] c1_d;
   logic [31:0]   c_d;

   assign a0 = a_rdata[15:0];
   assign a1 = a_rdata[31:16];
   assign b0 = b_rdata[15:0];
   assign b1 = b_rdata[31:16];

   assign p00_d = 32'(a0) * 32'(b0);
   assign p11_d = 32'(a1) * 32'(b1);
   assign px_d  = 33'(a0) * 33'(b1) + 33'(a1) * 33'(b0);
   assign m11_d = mod_q(RW'(p11_d));

   assign s0_d = RW'(p00_q) + RW'(m11_q) * RW'(g_q);
   assign c0_d = mod_q(s0_d);
   assign c1_d = mod_q(RW'(px_q));
   assign c_d  = {16'(c1_d), 16'(c0_d)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_RUN;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
               end
            end
            S_RUN: begin
               if (rd_addr_q == LAST) begin
                  rd_en_q <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  rd_addr_q <= rd_addr_q + 7'd1;
               end
            end
            S_DRAIN: begin
               if (c_we_q && (c_addr_q == LAST)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Read data arrives from the source register one cycle after rd_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_q <= 1'b0;
         rk_q <= '0;
      end else begin
         rv_q <= rd_en_q;
         rk_q <= rd_addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q  <= 1'b0;
         pk_q  <= '0;
         p00_q <= '0;
         m11_q <= '0;
         px_q  <= '0;
         g_q   <= '0;
      end else begin
         pv_q <= rv_q;
         if (rv_q) begin
            pk_q  <= rk_q;
            p00_q <= p00_d;
            m11_q <= m11_d;
            px_q  <= px_d;
            g_q   <= gamma_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_we_q    <= 1'b0;
         c_addr_q  <= '0;
         c_wdata_q <= '0;
      end else begin
         c_we_q <= pv_q;
         if (pv_q) begin
            c_addr_q  <= pk_q;
            c_wdata_q <= c_d;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign c_we    = c_we_q;
   assign c_addr  = c_addr_q;
   assign c_wdata = c_wdata_q;

endmodule

// File: tb/tb_base_mul_seq.sv
// Bench for base_mul_seq: timeline model of every output per cycle,
// modular arithmetic reference for each written pair.
module tb_base_mul_seq;

   localparam int Q  = 3329;
   localparam int NP = 128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [6:0]  rd_addr;
   logic [31:0] a_rdata = '0;
   logic [31:0] b_rdata = '0;
   logic [15:0] gamma_rdata = '0;
   logic        c_we;
   logic [6:0]  c_addr;
   logic [31:0] c_wdata;

   always #5 clk = ~clk;

   base_mul_seq #(.Q(Q), .NPAIR(NP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .busy(busy),
      .done(done),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .a_rdata(a_rdata),
      .b_rdata(b_rdata),
      .gamma_rdata(gamma_rdata),
      .c_we(c_we),
      .c_addr(c_addr),
      .c_wdata(c_wdata)
   );

   logic [31:0] mem_a [NP];
   logic [31:0] mem_b [NP];
   logic [15:0] mem_g [NP];

   always @(posedge clk) begin
      if (rd_en) begin
         a_rdata     <= mem_a[rd_addr];
         b_rdata     <= mem_b[rd_addr];
         gamma_rdata <= mem_g[rd_addr];
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input int k);
      longint a0, a1, b0, b1, g, c0, c1;
      a0 = longint'(mem_a[k][15:0]);
      a1 = longint'(mem_a[k][31:16]);
      b0 = longint'(mem_b[k][15:0]);
      b1 = longint'(mem_b[k][31:16]);
      g  = longint'(mem_g[k]);
      c0 = (a0 * b0 + ((a1 * b1) % Q) * g) % Q;
      c1 = (a0 * b1 + a1 * b0) % Q;
      return {16'(c1), 16'(c0)};
   endfunction

   task automatic fill_random();
      for (int k = 0; k < NP; k++) begin
         mem_a[k] = {16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1))};
         mem_b[k] = {16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1))};
         mem_g[k] = 16'($urandom_range(0, Q - 1));
      end
   endtask

   // e counts clock edges; E is the edge on which the current start was accepted.
   int e = 0;
   int E = -1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         E = -1;
      end else begin
         if (start && (E < 0 || e - E >= NP + 5)) E = e;
         e = e + 1;
      end
   end

   int          last_ra = 0;
   int          last_ca = 0;
   logic [31:0] last_cw = '0;
   int          nwr = 0;
   int          ndone = 0;
   logic [31:0] got [NP];

   always @(negedge clk) begin
      int   n;
      logic xr, xw, xb, xd;
      if (!rst_n) begin
         last_ra = 0;
         last_ca = 0;
         last_cw = '0;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_rd_en", 32'(rd_en), 32'd0);
         chk("rst_c_we", 32'(c_we), 32'd0);
         chk("rst_rd_addr", 32'(rd_addr), 32'd0);
         chk("rst_c_addr", 32'(c_addr), 32'd0);
         chk("rst_c_wdata", c_wdata, 32'd0);
      end else begin
         n  = (E < 0) ? 0 : e - E;
         xr = (n >= 1) && (n <= NP);
         xw = (n >= 4) && (n <= NP + 3);
         xb = (n >= 1) && (n <= NP + 3);
         xd = (n == NP + 4);
         if (xr) last_ra = n - 1;
         if (xw) begin
            last_ca = n - 4;
            last_cw = model(n - 4);
         end
         chk("busy", 32'(busy), 32'(xb));
         chk("done", 32'(done), 32'(xd));
         chk("rd_en", 32'(rd_en), 32'(xr));
         chk("rd_addr", 32'(rd_addr), 32'(last_ra));
         chk("c_we", 32'(c_we), 32'(xw));
         chk("c_addr", 32'(c_addr), 32'(last_ca));
         chk("c_wdata", c_wdata, last_cw);
         if (c_we) begin
            got[c_addr] = c_wdata;
            nwr++;
         end
         if (done) ndone++;
      end
   end

   task automatic run_op(input int pulse_at, input bit pulse_done);
      int lat;
      int w0;
      bit seen;
      w0 = nwr;
      seen = 1'b0;
      lat = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         lat++;
         start = (lat == pulse_at);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(NP + 4));
      chk("write_count", 32'(nwr - w0), 32'(NP));
      if (pulse_done && seen) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      int w0, d0;
      bit hit;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fill_random();
      mem_a[0] = {16'd0, 16'd1};
      mem_b[0] = {16'd0, 16'd1};
      mem_g[0] = 16'd17;
      mem_a[1] = {16'd1, 16'd0};
      mem_b[1] = {16'd1, 16'd0};
      mem_g[1] = 16'd17;
      mem_a[2] = {16'd3328, 16'd3328};
      mem_b[2] = {16'd3328, 16'd3328};
      mem_g[2] = 16'd3328;
      chk("model_pin0", model(0), 32'h0000_0001);
      chk("model_pin1", model(1), 32'h0000_0011);
      chk("model_pin2", model(2), 32'h0002_0000);
      run_op(-1, 1'b0);
      chk("pair0", got[0], 32'h0000_0001);
      chk("pair1", got[1], 32'h0000_0011);
      chk("pair2", got[2], 32'h0002_0000);

      repeat (3) @(negedge clk);
      fill_random();
      run_op(10, 1'b1);
      repeat (4) @(negedge clk);
      chk("idle_after_ignored_start", 32'(busy), 32'd0);

      fill_random();
      run_op(NP + 2, 1'b0);
      fill_random();
      run_op(-1, 1'b0);

      repeat (2) @(negedge clk);
      fill_random();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (rd_en && rd_addr == 7'd50) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_k50", 32'(hit), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd_en", 32'(rd_en), 32'd0);
      chk("abort_c_we", 32'(c_we), 32'd0);
      chk("abort_rd_addr", 32'(rd_addr), 32'd0);
      chk("abort_c_addr", 32'(c_addr), 32'd0);
      chk("abort_c_wdata", c_wdata, 32'd0);
      w0 = nwr;
      d0 = ndone;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (140) @(negedge clk);
      chk("abort_no_writes", 32'(nwr - w0), 32'd0);
      chk("abort_no_done", 32'(ndone - d0), 32'd0);

      fill_random();
      run_op(-1, 1'b0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/base_mul_seq.md
BASE_MUL_SEQ -- requirements
Module: base_mul_seq

Interface
REQ-001 SHALL have parameter Q, default 3329, the Kyber modulus.
REQ-002 SHALL have parameter NPAIR, default 128, coefficient pairs per polynomial.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request one full pointwise multiply.
REQ-006 SHALL have port busy  output  1  operation in progress.
REQ-007 SHALL have port done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port rd_en  output  1  read strobe for the A, B and gamma sources.
REQ-009 SHALL have port rd_addr  output  7  pair index k, shared by A, B and gamma.
REQ-010 SHALL have port a_rdata  input  32  {a1,a0} of pair k, valid 1 cycle after rd_en.
REQ-011 SHALL have port b_rdata  input  32  {b1,b0} of pair k, valid 1 cycle after rd_en.
REQ-012 SHALL have port gamma_rdata  input  16  gamma of pair k (zeta^(2*br7(k)+1) mod Q), valid 1 cycle after rd_en.
REQ-013 SHALL have port c_we  output  1  result write strobe.
REQ-014 SHALL have port c_addr  output  7  result pair index.
REQ-015 SHALL have port c_wdata  output  32  {c1,c0}.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 at edge T SHALL move to RUN; start in any other state SHALL be ignored.
REQ-018 RUN: rd_en=1, rd_addr=k at cycle T+1+k for k=0..NPAIR-1, with no gaps; after k=NPAIR-1 SHALL move to DRAIN.
REQ-019 Datapath SHALL register the read data (stage 1), register the products a0*b0, (a1*b1 mod Q), and a0*b1+a1*b0 (stage 2), then register the reduced results (stage 3).
REQ-020 c0 SHALL equal (a0*b0 + (a1*b1 mod Q)*gamma) mod Q; c1 SHALL equal (a0*b1 + a1*b0) mod Q; both in [0,Q-1].
REQ-021 Intermediate widths SHALL be wide enough for no overflow (at least 25 bits for sums of two 24-bit products); reduction SHALL be exact, not Barrett-approximate.
REQ-022 Inputs are in [0,Q-1]; gamma is supplied as a non-negative representative in [0,Q-1].
REQ-023 c_we=1 with c_addr=k and c_wdata for pair k SHALL occur at cycle T+4+k; writes SHALL be in ascending k with no gaps.
REQ-024 DRAIN SHALL last until the write of pair NPAIR-1 at T+3+NPAIR, then move to DONE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle (T+4+NPAIR) and return to IDLE; a start sampled in that cycle SHALL be ignored.
REQ-026 busy SHALL be 1 from T+1 through T+3+NPAIR inclusive, and 0 in IDLE and DONE.
REQ-027 rd_en and c_we SHALL be 0 outside the cycles given above; rd_addr and c_addr SHALL hold their last value when their strobes are low.
REQ-028 Index counters SHALL stop at NPAIR-1 and never wrap to 0 within an operation.
REQ-029 Back-to-back: start asserted in the cycle after done SHALL be accepted, so the next RUN begins 1 cycle later.

Reset
REQ-030 rst_n=0 SHALL, asynchronously, force state IDLE and drive busy, done, rd_en and c_we to 0, rd_addr, c_addr and c_wdata to 0, and clear all pipeline valid bits.
REQ-031 Reset asserted mid-operation SHALL abort it with no further c_we and no done pulse; the block SHALL be idle on the first edge after rst_n returns to 1.

Verification
REQ-032 Pair k=0 with a=(1,0), b=(1,0), gamma=17 -> c_wdata={16'd0,16'd1} at T+4.
REQ-033 a=(0,1), b=(0,1), gamma=17 -> c0=17, c1=0.
REQ-034 All inputs 3328, gamma=3328 -> c0=0, c1=2 (covers the maximum-width path).
REQ-035 Random full polynomials of 128 pairs checked against a golden model -> 128 writes at T+4..T+131, done at T+132, busy high for T+1..T+131.
REQ-036 start pulsed during RUN and in the DONE cycle -> ignored, exactly 128 writes per accepted start.
REQ-037 rst_n low at k=50 of RUN -> outputs 0 immediately, no done pulse; a new start after release completes normally.
